booth_dot_product_sequencer: RTL and testbench
==============================================

Name: booth_dot_product_sequencer

Overview:
- Drives the 4-bit radix-4 Booth multiplier as both its operand feeder and its result consumer.
- Accepts a stream of signed operand pairs ending in a "last" marker and issues one start/ready transaction per pair to the multiplier.
- Accumulates the 8-bit products into a saturating signed sum and presents the dot product, element count and status on a valid/ready output.
- Sits between the operand source and the multiplier in the MAC datapath.

Parameters:
- ACC_W, 12: accumulator and out_sum width in bits; must be >= 8.
- CNT_W, 7: width of the element counter and out_count.
- TIMEOUT, 15: maximum cycles spent in WAIT for mul_ready before the timeout error fires.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- in_valid  in  1  an operand pair is offered.
- in_ready  out  1  the sequencer can accept a pair.
- in_a  in  4  signed multiplicand.
- in_b  in  4  signed multiplier.
- in_last  in  1  the pair offered is the final element of the vector.
- mul_a  out  4  multiplicand to the multiplier; stable from LAUNCH through the end of WAIT.
- mul_b  out  4  multiplier operand to the multiplier; same stability as mul_a.
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_ready  in  1  multiplier result-valid indication.
- mul_p  in  8  signed product from the multiplier.
- out_valid  out  1  the dot-product result is valid.
- out_ready  in  1  the consumer accepts the result.
- out_sum  out  ACC_W  signed, saturated dot product.
- out_count  out  CNT_W  number of products accumulated into out_sum.
- out_ovf  out  1  saturation occurred during this vector.
- err_timeout  out  1  sticky flag: the multiplier failed to respond.

Behaviour:
- Reset: synchronous, active-high. Clears to 0: state (IDLE), accumulator, counter, mul_a, mul_b, mul_start, out_valid, out_ovf, err_timeout, last flag. in_ready is combinational and equals (state==IDLE), so it is 1 in the first cycle after reset.
- Reset mid-operation: abandons the vector; no partial output is produced. A mul_ready arriving later is ignored because the block is in IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: register in_a/in_b into mul_a/mul_b, register in_last, then go to LAUNCH.
  - mul_ready is ignored in IDLE.
- LAUNCH (exactly 1 cycle):
  - mul_start=1 as a registered output, high only in this cycle.
  - Timeout counter loaded with TIMEOUT.
  - mul_ready is ignored here, since the previous transaction's ready may still be high. Go to WAIT.
- WAIT:
  - If mul_ready=1: capture mul_p and go to ACCUM.
  - Otherwise decrement the counter. When it reaches 0, set err_timeout and go to OUTPUT with the partial sum.
  - With the current multiplier, ready arrives 4 cycles after the start pulse. Correctness must not depend on that number.
- ACCUM (1 cycle):
  - acc <= sat(acc + sign_extend(mul_p)), computed at ACC_W+1 bits.
  - Clamp to [-(2^(ACC_W-1)), 2^(ACC_W-1)-1]; any clamp sets out_ovf, which stays set until the vector's result is accepted.
  - count <= count + 1, saturating at the all-ones value.
  - If last=1 go to OUTPUT, else go to IDLE.
- OUTPUT:
  - out_valid=1; out_sum, out_count and out_ovf are held stable.
  - On out_ready: clear acc, count and out_ovf, then go to IDLE.
  - in_ready=0 throughout OUTPUT (backpressure to the source).
- err_timeout: sticky until reset; it does not block further vectors.
- Throughput: 1 (accept) + 1 (LAUNCH) + multiplier latency + 1 (ACCUM) cycles per element, plus the output handshake once per vector.
- Simultaneous in_valid and out_ready: cannot conflict, because input and output handshakes occur in different states.

Decomposition:
- Shared package booth_pkg holds:
  - MUL_W=4 and PROD_W=8;
  - the sequencer state enum {IDLE, LAUNCH, WAIT, ACCUM, OUTPUT};
  - a sign-extend/saturate function shared with future MAC blocks.
- One sub-module is natural: booth_sat_accumulator, parameterised by ACC_W, holding the clear/add-with-clamp datapath and the ovf output.

Test Plan:
- Single pair (3, -2, last=1) -> one mul_start pulse; out_valid with out_sum=-6, out_count=1, out_ovf=0.
- Vector (-8,-8), (7,7), (-8,7), (1,1 last) -> out_sum=58 (64+49-56+1), out_count=4.
- ACC_W=8 override, four pairs (-8,-8) -> out_sum=127, out_ovf=1, out_count=4.
- Hold out_ready low for 5 cycles after out_valid -> out_sum stable, in_ready=0 throughout; accepted on the cycle out_ready rises, then in_ready=1 on the next cycle.
- Bench model that never asserts mul_ready -> err_timeout=1 after TIMEOUT WAIT cycles, out_valid with out_count=0; a following good vector still completes correctly.
- Assert reset in WAIT, and feed the stale mul_ready in the first cycle after reset release -> no out_valid, acc=0, and the next vector (2,2,last) gives out_sum=4.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and arithmetic for the radix-4 Booth MAC datapath:
// operand/product widths, the sequencer state type and saturating accumulation.
package booth_pkg;
  localparam int unsigned MUL_W  = 4;
  localparam int unsigned PROD_W = 8;

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, ACCUM, OUTPUT} seq_state_e;

  typedef struct packed {
    logic [31:0] value;
    logic        ovf;
  } sat_result_t;

  // Sign-extends prod, adds it to acc and clamps the sum to the signed acc_w-bit range (acc_w <= 31).
  function automatic sat_result_t sat_add(input logic signed [31:0]       acc,
                                          input logic signed [PROD_W-1:0] prod,
                                          input int unsigned              acc_w);
    logic signed [31:0] sum;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    sat_result_t        r;
    sum     = acc + prod;
    hi      = (32'sd1 <<< (acc_w - 1)) - 32'sd1;
    lo      = -(32'sd1 <<< (acc_w - 1));
    r.value = sum;
    r.ovf   = 1'b0;
    if (sum > hi) begin
      r.value = hi;
      r.ovf   = 1'b1;
    end else if (sum < lo) begin
      r.value = lo;
      r.ovf   = 1'b1;
    end
    return r;
  endfunction
endpackage

// File: rtl/booth_sat_accumulator.sv
// Signed saturating accumulator: clears or adds one sign-extended product per cycle,
// with a sticky overflow flag that follows the accumulator's clear.
module booth_sat_accumulator
  import booth_pkg::*;
#(
  parameter int unsigned ACC_W = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              add_en,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  acc,
  output logic              ovf
);
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  sat_result_t      sum;

  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    sum   = sat_add(32'(signed'(acc_q)), prod, ACC_W);
    if (clear) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (add_en) begin
      acc_d = ACC_W'(sum.value);
      ovf_d = ovf_q | sum.ovf;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign acc = acc_q;
  assign ovf = ovf_q;
endmodule

// File: rtl/booth_dot_product_sequencer.sv
// Feeds operand pairs to the Booth multiplier one start/ready transaction at a time and
// accumulates the products into a saturated dot product offered on a valid/ready output.
module booth_dot_product_sequencer
  import booth_pkg::*;
#(
  parameter int unsigned ACC_W   = 12,
  parameter int unsigned CNT_W   = 7,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MUL_W-1:0]  in_a,
  input  logic [MUL_W-1:0]  in_b,
  input  logic              in_last,
  output logic [MUL_W-1:0]  mul_a,
  output logic [MUL_W-1:0]  mul_b,
  output logic              mul_start,
  input  logic              mul_ready,
  input  logic [PROD_W-1:0] mul_p,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf,
  output logic              err_timeout
);
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  seq_state_e        state_q, state_d;
  logic [MUL_W-1:0]  mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic              mul_start_q, mul_start_d;
  logic              last_q, last_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [PROD_W-1:0] prod_q, prod_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              out_valid_q, out_valid_d;
  logic              err_q, err_d;
  logic              acc_clear, acc_add;

  always_comb begin
    state_d     = state_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    mul_start_d = 1'b0;
    last_d      = last_q;
    tmo_d       = tmo_q;
    prod_d      = prod_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;
    acc_clear   = 1'b0;
    acc_add     = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mul_a_d     = in_a;
          mul_b_d     = in_b;
          last_d      = in_last;
          mul_start_d = 1'b1;
          state_d     = LAUNCH;
        end
      end
      LAUNCH: begin
        tmo_d   = TMO_W'(TIMEOUT);
        state_d = WAIT;
      end
      WAIT: begin
        if (mul_ready) begin
          prod_d  = mul_p;
          state_d = ACCUM;
        end else begin
          tmo_d = tmo_q - 1'b1;
          // The counter reaches 0 at the end of the TIMEOUT-th idle WAIT cycle.
          if (tmo_q <= TMO_W'(1)) begin
            err_d       = 1'b1;
            out_valid_d = 1'b1;
            state_d     = OUTPUT;
          end
        end
      end
      ACCUM: begin
        acc_add = 1'b1;
        if (count_q != '1) count_d = count_q + 1'b1;
        if (last_q) begin
          out_valid_d = 1'b1;
          state_d     = OUTPUT;
        end else begin
          state_d = IDLE;
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          acc_clear   = 1'b1;
          count_d     = '0;
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_start_q <= 1'b0;
      last_q      <= 1'b0;
      tmo_q       <= '0;
      prod_q      <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      mul_start_q <= mul_start_d;
      last_q      <= last_d;
      tmo_q       <= tmo_d;
      prod_q      <= prod_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  booth_sat_accumulator #(.ACC_W(ACC_W)) u_acc (
    .clock  (clock),
    .reset  (reset),
    .clear  (acc_clear),
    .add_en (acc_add),
    .prod   (prod_q),
    .acc    (out_sum),
    .ovf    (out_ovf)
  );

  assign in_ready    = (state_q == IDLE);
  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;
  assign mul_start   = mul_start_q;
  assign out_valid   = out_valid_q;
  assign out_count   = count_q;
  assign err_timeout = err_q;
endmodule

// File: tb/tb_booth_dot_product_sequencer.sv
// Bench for the dot-product sequencer: a 12-bit and an 8-bit accumulator instance share stimulus
// and a behavioural multiplier; results are compared against an integer dot-product model.
module tb_booth_dot_product_sequencer;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic       in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [3:0] in_a = '0, in_b = '0;
  logic       in_ready, mul_start, out_valid, out_ovf, err_timeout;
  logic [3:0] mul_a, mul_b;
  logic       mul_ready;
  logic [7:0] mul_p;
  logic [11:0] out_sum;
  logic [6:0]  out_count;

  logic       r8_in_ready, r8_mul_start, r8_out_valid, r8_out_ovf, r8_err;
  logic [3:0] r8_mul_a, r8_mul_b;
  logic [7:0] r8_out_sum;
  logic [6:0] r8_out_count;

  int checks = 0;
  int failures = 0;

  booth_dot_product_sequencer dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .mul_a(mul_a), .mul_b(mul_b),
    .mul_start(mul_start), .mul_ready(mul_ready), .mul_p(mul_p),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_count(out_count), .out_ovf(out_ovf), .err_timeout(err_timeout)
  );

  booth_dot_product_sequencer #(.ACC_W(8)) dut8 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(r8_in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .mul_a(r8_mul_a), .mul_b(r8_mul_b),
    .mul_start(r8_mul_start), .mul_ready(mul_ready), .mul_p(mul_p),
    .out_valid(r8_out_valid), .out_ready(out_ready), .out_sum(r8_out_sum),
    .out_count(r8_out_count), .out_ovf(r8_out_ovf), .err_timeout(r8_err)
  );

  // Behavioural multiplier: answers each start pulse with a one-cycle ready after lat cycles.
  logic              mul_enable = 1'b1;
  int                lat = 4;
  logic              model_ready = 1'b0;
  logic signed [7:0] model_p = '0;
  logic              inj_ready = 1'b0;
  logic [7:0]        inj_p = '0;
  logic              busy = 1'b0;
  int                left = 0;
  logic signed [3:0] pa = '0, pb = '0;

  assign mul_ready = model_ready | inj_ready;
  assign mul_p     = inj_ready ? inj_p : model_p;

  always @(posedge clock) begin
    model_ready <= 1'b0;
    if (reset) begin
      busy <= 1'b0;
    end else if (mul_start && mul_enable) begin
      busy <= 1'b1;
      left <= lat;
      pa   <= mul_a;
      pb   <= mul_b;
    end else if (busy) begin
      if (left <= 1) begin
        busy        <= 1'b0;
        model_ready <= 1'b1;
        model_p     <= pa * pb;
      end else begin
        left <= left - 1;
      end
    end
  end

  int   cyc = 0, start_cnt = 0, start_cyc = 0, valid_cyc = 0;
  logic prev_valid = 1'b0;
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (mul_start) begin
      start_cnt <= start_cnt + 1;
      start_cyc <= cyc;
    end
    if (out_valid && !prev_valid) valid_cyc <= cyc;
    prev_valid <= out_valid;
  end

  function automatic void ref_dot(input int a[$], input int b[$], input int accw,
                                  output int sum, output bit ovf, output int cnt);
    int hi = (1 << (accw - 1)) - 1;
    int lo = -(1 << (accw - 1));
    sum = 0;
    ovf = 1'b0;
    foreach (a[i]) begin
      sum += a[i] * b[i];
      if (sum > hi) begin sum = hi; ovf = 1'b1; end
      else if (sum < lo) begin sum = lo; ovf = 1'b1; end
    end
    cnt = (a.size() > 127) ? 127 : a.size();
  endfunction

  task automatic send_pair(input int a, input int b, input logic last, output bit ok);
    int unsigned n = 0;
    @(negedge clock);
    in_valid = 1'b1; in_a = 4'(a); in_b = 4'(b); in_last = last;
    while (!in_ready && n < 500) begin @(negedge clock); n++; end
    ok = in_ready;
    @(negedge clock);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_out(output bit ok);
    int unsigned n = 0;
    while (!out_valid && n < 500) begin @(negedge clock); n++; end
    ok = out_valid;
  endtask

  task automatic run_vector(input int a[$], input int b[$], output bit ok);
    bit k;
    ok = 1'b1;
    foreach (a[i]) begin
      send_pair(a[i], b[i], logic'(i == a.size() - 1), k);
      ok &= k;
    end
    wait_out(k);
    ok &= k;
  endtask

  task automatic accept_out();
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    checks++; if (in_ready !== 1'b1 || r8_in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b/%b expected 1", in_ready, r8_in_ready); end
    checks++; if (out_valid !== 1'b0 || mul_start !== 1'b0) begin failures++; $display("FAIL reset_valid_start: got %b/%b expected 0/0", out_valid, mul_start); end
    checks++; if (out_sum !== '0 || out_count !== '0 || out_ovf !== 1'b0 || err_timeout !== 1'b0) begin
      failures++; $display("FAIL reset_outputs: sum=%0d count=%0d ovf=%b err=%b expected all 0", out_sum, out_count, out_ovf, err_timeout); end
  endtask

  task automatic test_single();
    bit ok;
    int s0 = start_cnt;
    int a[$] = '{3};
    int b[$] = '{-2};
    run_vector(a, b, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_handshake: got no out_valid expected out_valid"); end
    checks++; if (start_cnt - s0 !== 1) begin failures++; $display("FAIL single_starts: got %0d pulses expected 1", start_cnt - s0); end
    checks++; if (int'($signed(out_sum)) !== -6) begin failures++; $display("FAIL single_sum: got %0d expected -6", $signed(out_sum)); end
    checks++; if (out_count !== 7'd1 || out_ovf !== 1'b0) begin failures++; $display("FAIL single_count_ovf: got %0d/%b expected 1/0", out_count, out_ovf); end
    accept_out();
  endtask

  task automatic test_vectors();
    int exp12[2] = '{58, 256};
    int exp8[2]  = '{58, 127};
    bit ovf8[2]  = '{1'b0, 1'b1};
    for (int v = 0; v < 2; v++) begin
      int a[$];
      int b[$];
      bit ok;
      if (v == 0) begin a = '{-8, 7, -8, 1}; b = '{-8, 7, 7, 1}; end
      else begin a = '{-8, -8, -8, -8}; b = '{-8, -8, -8, -8}; end
      run_vector(a, b, ok);
      checks++; if (!ok) begin failures++; $display("FAIL vec%0d_handshake: got no out_valid expected out_valid", v); end
      checks++; if (int'($signed(out_sum)) !== exp12[v] || out_ovf !== 1'b0) begin
        failures++; $display("FAIL vec%0d_sum12: got %0d ovf=%b expected %0d ovf=0", v, $signed(out_sum), out_ovf, exp12[v]); end
      checks++; if (int'($signed(r8_out_sum)) !== exp8[v] || r8_out_ovf !== ovf8[v]) begin
        failures++; $display("FAIL vec%0d_sum8: got %0d ovf=%b expected %0d ovf=%b", v, $signed(r8_out_sum), r8_out_ovf, exp8[v], ovf8[v]); end
      checks++; if (out_count !== 7'd4 || r8_out_count !== 7'd4) begin
        failures++; $display("FAIL vec%0d_count: got %0d/%0d expected 4", v, out_count, r8_out_count); end
      accept_out();
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit bad = 1'b0;
    int a[$] = '{5};
    int b[$] = '{-3};
    run_vector(a, b, ok);
    checks++; if (!ok) begin failures++; $display("FAIL bp_handshake: got no out_valid expected out_valid"); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || int'($signed(out_sum)) !== -15) bad = 1'b1;
    end
    checks++; if (bad) begin failures++; $display("FAIL bp_hold: got unstable valid/ready/sum expected valid=1 ready=0 sum=-15"); end
    accept_out();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_release: got valid=%b ready=%b expected 0/1", out_valid, in_ready); end
    checks++; if (out_sum !== '0 || out_count !== '0) begin
      failures++; $display("FAIL bp_clear: got sum=%0d count=%0d expected 0/0", out_sum, out_count); end
  endtask

  task automatic test_timeout();
    bit ok;
    int s, c, s8, c8;
    bit o, o8;
    int a[$];
    int b[$];
    mul_enable = 1'b0;
    send_pair(1, 1, 1'b1, ok);
    wait_out(ok);
    checks++; if (!ok || err_timeout !== 1'b1) begin failures++; $display("FAIL timeout_flag: got valid=%b err=%b expected 1/1", out_valid, err_timeout); end
    checks++; if (out_count !== '0 || out_sum !== '0) begin failures++; $display("FAIL timeout_partial: got sum=%0d count=%0d expected 0/0", out_sum, out_count); end
    accept_out();
    checks++; if (valid_cyc - start_cyc !== 16) begin failures++; $display("FAIL timeout_cycles: got %0d expected 16", valid_cyc - start_cyc); end
    mul_enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a.push_back(int'($urandom_range(0, 15)) - 8);
      b.push_back(int'($urandom_range(0, 15)) - 8);
    end
    ref_dot(a, b, 12, s, o, c);
    ref_dot(a, b, 8, s8, o8, c8);
    run_vector(a, b, ok);
    checks++; if (!ok || int'($signed(out_sum)) !== s || out_count !== 7'(c) || int'($signed(r8_out_sum)) !== s8) begin
      failures++; $display("FAIL timeout_recover: got %0d/%0d count %0d expected %0d/%0d count %0d", $signed(out_sum), $signed(r8_out_sum), out_count, s, s8, c); end
    checks++; if (err_timeout !== 1'b1) begin failures++; $display("FAIL timeout_sticky: got %b expected 1", err_timeout); end
    accept_out();
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen = 1'b0;
    int a[$] = '{2};
    int b[$] = '{2};
    lat = 6;
    send_pair(5, 5, 1'b0, ok);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    inj_ready = 1'b1; inj_p = 8'd25;
    @(negedge clock);
    inj_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) seen = 1'b1;
    end
    checks++; if (seen) begin failures++; $display("FAIL rstmid_quiet: got activity after reset expected idle"); end
    checks++; if (out_sum !== '0 || out_count !== '0 || err_timeout !== 1'b0) begin
      failures++; $display("FAIL rstmid_state: got sum=%0d count=%0d err=%b expected 0/0/0", out_sum, out_count, err_timeout); end
    lat = 4;
    run_vector(a, b, ok);
    checks++; if (!ok || int'($signed(out_sum)) !== 4 || out_count !== 7'd1 || out_ovf !== 1'b0) begin
      failures++; $display("FAIL rstmid_next: got sum=%0d count=%0d ovf=%b expected 4/1/0", $signed(out_sum), out_count, out_ovf); end
    accept_out();
  endtask

  task automatic test_random();
    for (int v = 0; v < 7; v++) begin
      int a[$];
      int b[$];
      int s, c, s8, c8;
      bit o, o8, ok;
      int n = (v == 6) ? 130 : int'($urandom_range(1, 6));
      for (int i = 0; i < n; i++) begin
        a.push_back(int'($urandom_range(0, 15)) - 8);
        b.push_back(int'($urandom_range(0, 15)) - 8);
      end
      lat = int'($urandom_range(1, 6));
      ref_dot(a, b, 12, s, o, c);
      ref_dot(a, b, 8, s8, o8, c8);
      run_vector(a, b, ok);
      repeat ($urandom_range(0, 3)) @(negedge clock);
      checks++; if (!ok || int'($signed(out_sum)) !== s || out_ovf !== o || out_count !== 7'(c)) begin
        failures++; $display("FAIL rand%0d_acc12: got %0d ovf=%b count=%0d expected %0d ovf=%b count=%0d", v, $signed(out_sum), out_ovf, out_count, s, o, c); end
      checks++; if (int'($signed(r8_out_sum)) !== s8 || r8_out_ovf !== o8 || r8_out_count !== 7'(c8)) begin
        failures++; $display("FAIL rand%0d_acc8: got %0d ovf=%b count=%0d expected %0d ovf=%b count=%0d", v, $signed(r8_out_sum), r8_out_ovf, r8_out_count, s8, o8, c8); end
      accept_out();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_vectors();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end
endmodule
